video_palaccess: RTL and testbench
==================================

// Module: video_palaccess
// PURPOSE
//  CPU-side access sequencer for the 16-entry, 6-bit video palette in the pixel/border mixer.
//  The palette is indexed only by the mixer's current colour, i.e. border when outside the
//  pixel window. This block forces the border index and waits for an out-of-window cycle.
//  It then issues the palette write strobe, or captures the palette readback word.
//  Sits between the port decoder and the palette/frame mixer; owns the mixer border input.
// PARAMETERS
//  TIMEOUT   2048  max cycles spent in WAIT before the access is aborted (>=2)
//  TMO_W     11    width of the timeout counter; must hold TIMEOUT-1
// PORTS
//  clk          in   1  28MHz video clock
//  rst_n        in   1  synchronous active-low reset
//  hpix, vpix   in   1  pixel-window qualifiers, same-cycle copies of the mixer's inputs
//  zx_border    in   4  border colour from port FE
//  border_out   out  4  border index driven to mixer (registered)
//  cpu_req      in   1  1-cycle request strobe; sampled only when busy=0
//  cpu_wrnrd    in   1  1=palette write, 0=palette read
//  cpu_idx      in   4  palette index
//  cpu_data     in   6  write data
//  atm_palwr    out  1  palette write strobe to mixer
//  atm_paldata  out  6  palette write data (registered, held through access)
//  palcolor     in   6  mixer palette readback register
//  busy         out  1  access in progress (state != IDLE)
//  done         out  1  1-cycle completion pulse
//  err          out  1  set with done when the access timed out; cleared on next accept
//  rd_data      out  6  last read result, valid from done, held until next read completes
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, border_out=0, atm_paldata=0, rd_data=0, err=0,
//   counter=0; atm_palwr/done/busy=0. Reset mid-access aborts it: no palwr, no done.
//  win = hpix & vpix (combinational).
//  IDLE : border_out <= zx_border every cycle (1-cycle lag). On cpu_req: latch idx/wrnrd,
//   atm_paldata <= cpu_data, err <= 0, counter <= 0 -> SETUP.
//  SETUP: border_out <= idx -> WAIT. (From the next cycle, mixer colour = idx whenever !win.)
//  WAIT : counter++ each cycle.
//   !win & write -> atm_palwr=1 this cycle (combinational: state==WAIT & wr & !win) -> DONE.
//   !win & read  -> RDCAP.
//   win & counter==TIMEOUT-1 -> err <= 1 -> DONE with no palwr.
//   Same cycle !win & counter==TIMEOUT-1 -> the access succeeds, not the timeout.
//  RDCAP: rd_data <= palcolor. This is palette[idx] as registered at the WAIT edge. -> DONE.
//  DONE : done=1 for this cycle only; border_out <= zx_border -> IDLE.
//  cpu_req while busy=1, including the DONE cycle, is ignored; it is not queued.
//  atm_palwr is high for exactly one cycle per successful write and is never high while win=1.
//  zx_border changes during an access have no effect until DONE.
//  Latency with win=0, req at cycle 0:
//   write: palwr in cycle 2, done in cycle 3.
//   read:  done in cycle 4, rd_data valid in cycle 4.
//  With win=1 at request time, WAIT stretches until the first !win cycle.
// TESTING
//  1 win=0, req wr idx=5 data=6'h2A @c0 -> border_out=5 c2, palwr=1 c2 only, paldata=2A, done c3, err=0.
//  2 win=1 for c0..c11, then 0; req wr idx=3 @c0 -> palwr low through c11, pulses c12, done c13.
//  3 After test 1: req rd idx=5, win=0, model palette -> done c4, rd_data=6'h2A, no palwr.
//  4 TIMEOUT=8, win held 1; req wr -> done 8 cycles after first WAIT cycle, err=1, palwr never high.
//  5 Second req at c1 and at the done cycle -> ignored; exactly one done and one palwr.
//  6 rst_n=0 in WAIT with win=1 -> next cycle busy=0, border_out=0, no palwr/done; zx_border=7 shows c+2.

Source files
------------

// File: rtl/video_palaccess.sv
// CPU access sequencer for the 16-entry video palette: steers the mixer border index to the
// requested entry, waits for an out-of-window cycle, then strobes a write or captures readback.
module video_palaccess #(
  parameter int TIMEOUT = 2048,
  parameter int TMO_W   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hpix,
  input  logic       vpix,
  input  logic [3:0] zx_border,
  output logic [3:0] border_out,
  input  logic       cpu_req,
  input  logic       cpu_wrnrd,
  input  logic [3:0] cpu_idx,
  input  logic [5:0] cpu_data,
  output logic       atm_palwr,
  output logic [5:0] atm_paldata,
  input  logic [5:0] palcolor,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] rd_data
);

  // state  | meaning
  // IDLE   | border follows zx_border, accepts cpu_req
  // SETUP  | border index forced to the requested palette entry
  // WAIT   | waiting for an out-of-window cycle, timeout counter running
  // RDCAP  | capture palette readback for a read
  // DONE   | completion pulse, border handed back to zx_border
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_RDCAP,
    S_DONE
  } state_t;

  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [5:0]       paldata_q, paldata_d;
  logic [5:0]       rd_q, rd_d;
  logic             err_q, err_d;
  logic [3:0]       border_q, border_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             win;
  logic             palwr;
  logic             done_p;

  assign win = hpix & vpix;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    paldata_d = paldata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    border_d  = border_q;
    cnt_d     = cnt_q;
    palwr     = 1'b0;
    done_p    = 1'b0;
    case (state_q)
      S_IDLE: begin
        border_d = zx_border;
        if (cpu_req) begin
          idx_d     = cpu_idx;
          wr_d      = cpu_wrnrd;
          paldata_d = cpu_data;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        border_d = idx_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        // An out-of-window cycle wins over a simultaneous timeout.
        if (!win) begin
          if (wr_q) begin
            palwr   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RDCAP;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RDCAP: begin
        rd_d    = palcolor;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_p   = 1'b1;
        border_d = zx_border;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      paldata_q <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      border_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      paldata_q <= paldata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      border_q  <= border_d;
      cnt_q     <= cnt_d;
    end
  end

  assign border_out  = border_q;
  assign atm_palwr   = palwr;
  assign atm_paldata = paldata_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_p;
  assign err         = err_q;
  assign rd_data     = rd_q;

endmodule

// File: tb/tb_video_palaccess.sv
// Bench for video_palaccess: two instances (default timeout and TIMEOUT=8) share stimulus;
// a small mixer/palette environment feeds readback and a transaction-level model predicts results.
module tb_video_palaccess;

  logic       clk = 1'b0;
  logic       rst_n, hpix, vpix, cpu_req, cpu_wrnrd;
  logic [3:0] zx_border, cpu_idx, pix;
  logic [5:0] cpu_data;

  logic [3:0] bo[2];
  logic       pw[2], bsy[2], dn[2], er[2];
  logic [5:0] pd[2], rd[2], pc[2];

  logic [5:0] env_pal[2][16];
  logic [5:0] ref_pal[2][16];
  logic [5:0] last_rd[2];
  logic [3:0] zx_prev;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_palaccess u_main (
    .clk(clk), .rst_n(rst_n), .hpix(hpix), .vpix(vpix), .zx_border(zx_border),
    .border_out(bo[0]), .cpu_req(cpu_req), .cpu_wrnrd(cpu_wrnrd), .cpu_idx(cpu_idx),
    .cpu_data(cpu_data), .atm_palwr(pw[0]), .atm_paldata(pd[0]), .palcolor(pc[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]), .rd_data(rd[0])
  );

  video_palaccess #(.TIMEOUT(8), .TMO_W(3)) u_tmo (
    .clk(clk), .rst_n(rst_n), .hpix(hpix), .vpix(vpix), .zx_border(zx_border),
    .border_out(bo[1]), .cpu_req(cpu_req), .cpu_wrnrd(cpu_wrnrd), .cpu_idx(cpu_idx),
    .cpu_data(cpu_data), .atm_palwr(pw[1]), .atm_paldata(pd[1]), .palcolor(pc[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]), .rd_data(rd[1])
  );

  // Mixer environment: current colour is the pixel index inside the window, else the border.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] col;
      col = (hpix & vpix) ? pix : bo[i];
      if (!rst_n) begin
        for (int k = 0; k < 16; k++) env_pal[i][k] <= ref_pal[i][k];
        pc[i] <= '0;
      end else begin
        if (pw[i]) env_pal[i][col] <= pd[i];
        pc[i] <= env_pal[i][col];
      end
    end
  end

  function automatic int tmo_of(input int i);
    return (i == 0) ? 2048 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit req, input bit wr, input logic [3:0] idx,
                        input logic [5:0] data, input bit win, input logic [3:0] zx);
    zx_prev   = zx_border;
    zx_border = zx;
    cpu_req   = req;
    cpu_wrnrd = wr;
    cpu_idx   = idx;
    cpu_data  = data;
    pix       = 4'($urandom);
    if (win) begin
      hpix = 1'b1;
      vpix = 1'b1;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin hpix = 1'b0; vpix = 1'b0; end
        1:       begin hpix = 1'b0; vpix = 1'b1; end
        default: begin hpix = 1'b1; vpix = 1'b0; end
      endcase
    end
  endtask

  task automatic idle();
    set_in(1'b0, 1'($urandom), 4'($urandom), 6'($urandom), 1'($urandom), 4'($urandom));
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle i%0d busy", i), 32'(bsy[i]), 0);
      chk($sformatf("idle i%0d border", i), 32'(bo[i]), 32'(zx_prev));
      chk($sformatf("idle i%0d palwr", i), 32'(pw[i]), 0);
    end
    tick();
  endtask

  // One access: win held high for g WAIT cycles (and during c0/c1 when g>0), then released.
  task automatic run_txn(input string tag, input bit wr, input logic [3:0] idx,
                         input logic [5:0] data, input int g, input int xa, input int xb);
    int  done_c[2], wr_c[2], maxd;
    bit  tmo[2];
    bit  w;
    logic [5:0] exp_rd;
    for (int i = 0; i < 2; i++) begin
      if (g <= tmo_of(i) - 1) begin
        tmo[i]    = 1'b0;
        wr_c[i]   = wr ? 2 + g : -1;
        done_c[i] = wr ? 3 + g : 4 + g;
      end else begin
        tmo[i]    = 1'b1;
        wr_c[i]   = -1;
        done_c[i] = 2 + tmo_of(i);
      end
    end
    maxd = (done_c[0] > done_c[1]) ? done_c[0] : done_c[1];
    for (int c = 0; c <= maxd + 1; c++) begin
      if (c < 2 + g) w = (c >= 2) || (g > 0);
      else if (c == 2 + g) w = 1'b0;
      else w = 1'($urandom);
      if (c == 0) set_in(1'b1, wr, idx, data, w, 4'($urandom));
      else set_in((c == xa) || (c == xb), 1'($urandom), 4'($urandom), 6'($urandom), w,
                  4'($urandom));
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s i%0d c%0d busy", tag, i, c), 32'(bsy[i]),
            32'((c >= 1) && (c <= done_c[i])));
        chk($sformatf("%s i%0d c%0d done", tag, i, c), 32'(dn[i]), 32'(c == done_c[i]));
        chk($sformatf("%s i%0d c%0d palwr", tag, i, c), 32'(pw[i]), 32'(c == wr_c[i]));
        chk($sformatf("%s i%0d c%0d border", tag, i, c), 32'(bo[i]),
            32'(((c >= 2) && (c <= done_c[i])) ? idx : zx_prev));
        if (c >= 1 && c <= done_c[i])
          chk($sformatf("%s i%0d c%0d paldata", tag, i, c), 32'(pd[i]), 32'(data));
        if (c == 1) chk($sformatf("%s i%0d err clr", tag, i), 32'(er[i]), 0);
        if (c == done_c[i]) begin
          chk($sformatf("%s i%0d err", tag, i), 32'(er[i]), 32'(tmo[i]));
          exp_rd = (!tmo[i] && !wr) ? ref_pal[i][idx] : last_rd[i];
          chk($sformatf("%s i%0d rd_data", tag, i), 32'(rd[i]), 32'(exp_rd));
          last_rd[i] = exp_rd;
          if (!tmo[i] && wr) ref_pal[i][idx] = data;
        end
      end
      tick();
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    zx_border = '0; zx_prev = '0; cpu_req = 1'b0; cpu_wrnrd = 1'b0;
    cpu_idx = '0; cpu_data = '0; hpix = 1'b0; vpix = 1'b0; pix = '0;
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = '0;
      for (int k = 0; k < 16; k++) ref_pal[i][k] = 6'($urandom);
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst i%0d busy", i), 32'(bsy[i]), 0);
      chk($sformatf("rst i%0d border", i), 32'(bo[i]), 0);
      chk($sformatf("rst i%0d paldata", i), 32'(pd[i]), 0);
      chk($sformatf("rst i%0d rd_data", i), 32'(rd[i]), 0);
      chk($sformatf("rst i%0d err", i), 32'(er[i]), 0);
      chk($sformatf("rst i%0d done", i), 32'(dn[i]), 0);
      chk($sformatf("rst i%0d palwr", i), 32'(pw[i]), 0);
    end
    rst_n = 1'b1;
    idle();
    idle();

    run_txn("wr_basic", 1'b1, 4'd5, 6'h2A, 0, -1, -1);
    run_txn("rd_basic", 1'b0, 4'd5, 6'h00, 0, -1, -1);
    chk("rd_basic value", 32'(rd[0]), 32'h2A);
    run_txn("wr_window", 1'b1, 4'd3, 6'h15, 10, -1, -1);
    run_txn("wr_ignore", 1'b1, 4'd9, 6'h33, 0, 1, 3);
    run_txn("wr_timeout", 1'b1, 4'd6, 6'h0F, 12, -1, -1);
    run_txn("rd_edge_ok", 1'b0, 4'd3, 6'h00, 7, -1, -1);
    run_txn("wr_edge_ok", 1'b1, 4'd12, 6'h3C, 7, -1, -1);
    run_txn("rd_edge_tmo", 1'b0, 4'd12, 6'h00, 8, -1, -1);
    idle();

    // Reset while waiting inside the window aborts the access.
    set_in(1'b1, 1'b1, 4'd9, 6'h11, 1'b1, 4'd2); #1; tick();
    set_in(1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 4'd2); #1; tick();
    set_in(1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 4'd2); #1;
    chk("rst6 wait busy", 32'(bsy[0]), 1);
    tick();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 4'd2); #1; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) last_rd[i] = '0;
    set_in(1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 4'd7); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst6 i%0d busy", i), 32'(bsy[i]), 0);
      chk($sformatf("rst6 i%0d border", i), 32'(bo[i]), 0);
      chk($sformatf("rst6 i%0d palwr", i), 32'(pw[i]), 0);
      chk($sformatf("rst6 i%0d done", i), 32'(dn[i]), 0);
      chk($sformatf("rst6 i%0d rd_data", i), 32'(rd[i]), 0);
    end
    tick();
    set_in(1'b0, 1'b0, 4'd0, 6'h00, 1'b0, 4'd1); #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("rst6 i%0d border7", i), 32'(bo[i]), 32'd7);
    tick();
    idle();

    for (int n = 0; n < 40; n++) begin
      int  g, xa;
      bit  wr;
      g  = $urandom_range(0, 12);
      wr = 1'($urandom);
      xa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1;
      run_txn($sformatf("rnd%0d", n), wr, 4'($urandom), 6'($urandom), g, xa, -1);
      if ($urandom_range(0, 1) == 1) idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
